deserializer: RTL and testbench
===============================

# deserializer

Serial-to-parallel front end of the deserializer datapath. Collects one bit per `write_in` strobe, assembles `WIDTH`-bit words MSB-first, and presents each completed word to the downstream 8-entry queue stage with a ready/ack handshake. While a word waits for acknowledgement the block reports busy and drops incoming bits. Runs in the same single clock domain as the queue.

## Interface

Parameters:
- `WIDTH`, 8, word width in bits; must match the queue entry width.

Ports:
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  1  serial data bit; sampled only when `write_in`=1.
- `write_in`  in  1  bit strobe; one bit accepted per cycle high, when not busy.
- `ack_in`  in  1  downstream consumed the word; meaningful only while `data_ready`=1.
- `data_out`  out  WIDTH  assembled word; stable while `data_ready`=1.
- `data_ready`  out  1  word valid, waiting for `ack_in`.
- `status_out`  out  1  busy: 1 while holding an unacknowledged word; bits are dropped.
- `parity_err_out`  out  1  present only with `DESER_PARITY_EN`; one-cycle error pulse.

## Operation

- Reset: `data_out`=0, `data_ready`=0, `status_out`=0, `parity_err_out`=0, bit counter=0, state COLLECT.
- Reset mid-word or mid-handshake discards the partial or pending word; nothing reaches the queue.
- State COLLECT:
  - On `write_in`=1, shift register takes `{shreg[WIDTH-2:0], data_in}`. The first bit received ends up in `data_out[WIDTH-1]`.
  - The counter increments. Its width is `$clog2(WIDTH+1)`.
  - On the `WIDTH`-th accepted bit: load `data_out` with the full word, clear the counter, and go to READY.
  - `ack_in` is ignored in COLLECT.
- State READY:
  - `data_ready`=1 and `status_out`=1.
  - `write_in` is ignored and the bit is lost.
  - On `ack_in`=1: `data_ready`→0, `status_out`→0, go to COLLECT.
  - `ack_in` and `write_in` in the same cycle: the ack is taken and the bit is dropped.
- `data_out` holds the last completed word after ack, until the next word completes.
- Pauses between strobes of any length are legal. There is no timeout, and partial words persist indefinitely.

## Timing

- Latency: the `WIDTH`-th strobe is sampled at edge k. After edge k, `data_ready`=1, `status_out`=1, and `data_out` is valid.
- Ack sampled at edge m drops `data_ready` and `status_out` after edge m.
- A `write_in` at edge m+1 is accepted as bit 0 of the next word.
- Minimum word period: `WIDTH` cycles plus 1 ack cycle.
- A one-cycle `ack_in` pulse is sufficient. Holding `ack_in` high continuously gives `WIDTH`+1 cycles per word, with no stall.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- Macro: `DESER_PARITY_EN`.
- Defined:
  - Each frame is `WIDTH` data bits followed by one even-parity bit. The parity bit is the XOR of the data bits.
  - The counter counts to `WIDTH`+1.
  - If parity matches on the final bit: same behaviour as the WIDTH-th bit above, i.e. go to READY.
  - On mismatch: the word is discarded, `data_out` is unchanged, the state stays COLLECT, the counter clears, and `parity_err_out`=1 for exactly one cycle after that edge.
- Undefined:
  - Frames are `WIDTH` bits.
  - The `parity_err_out` port does not exist.
  - No parity logic is synthesized.

## Test plan

- Reset, then 8 strobes of bits 1,0,1,1,0,0,1,0.
  - `data_out`=0xB2 and `data_ready`=1 one cycle after the 8th strobe.
  - `status_out`=1.
  - Before the 8th strobe, `data_ready`=0 and `data_out`=0x00.
- Hold a word 0xB2 without ack, then send 3 more strobes.
  - The bits are ignored and `data_out` stays 0xB2.
  - Pulse `ack_in`. `data_ready`=0 next cycle.
  - Then 8 strobes of 0xFF give `data_out`=0xFF.
- `ack_in` tied high with strobes every cycle.
  - Words 0x01, 0x80, 0x5A appear back-to-back.
  - `data_ready` is high one cycle in every 9.
- Apply `reset` after 5 of 8 bits, then send 8 strobes of 0x3C.
  - `data_out`=0x3C; there is no residue from the partial word.
  - Apply `reset` while `data_ready`=1: all outputs return to 0 next cycle.
- Strobe gaps of 0–20 idle cycles plus simultaneous `ack_in`/`write_in` in READY.
  - Words 0xC3 and 0x0F are delivered intact.
  - The colliding bit is dropped.
- With `DESER_PARITY_EN`:
  - 0xB2 with parity 0 gives `data_ready`.
  - 0xB2 with parity 1 gives a one-cycle `parity_err_out` pulse, no `data_ready`, and `data_out` unchanged.

Source files
------------

// File: rtl/deserializer_if.sv
`default_nettype none
// ============================================================================
// Module      : deserializer_if
// Description : Serial-bit input and word/handshake output bundle of the
//               deserializer. DESER_PARITY_EN adds parity_err_out.
// Revision    : 1.0 - initial release
// ============================================================================
interface deserializer_if #(
    parameter int WIDTH = 8
);
    logic             data_in;
    logic             write_in;
    logic             ack_in;
    logic [WIDTH-1:0] data_out;
    logic             data_ready;
    logic             status_out;
`ifdef DESER_PARITY_EN
    logic             parity_err_out;

    modport master (
        output data_in, write_in, ack_in,
        input  data_out, data_ready, status_out, parity_err_out
    );
    modport slave (
        input  data_in, write_in, ack_in,
        output data_out, data_ready, status_out, parity_err_out
    );
`else
    modport master (
        output data_in, write_in, ack_in,
        input  data_out, data_ready, status_out
    );
    modport slave (
        input  data_in, write_in, ack_in,
        output data_out, data_ready, status_out
    );
`endif
endinterface
`default_nettype wire

// File: rtl/deserializer.sv
`default_nettype none
// ============================================================================
// Module      : deserializer
// Description : Collects MSB-first serial bits into WIDTH-bit words and holds
//               each word for a ready/ack handshake. DESER_PARITY_EN appends
//               an even-parity bit to every frame and flags mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module deserializer #(
    parameter int WIDTH = 8
) (
    input  wire logic     clock,
    input  wire logic     reset,
    deserializer_if.slave bus
);

`ifdef DESER_PARITY_EN
    localparam int c_FRAME_LEN = WIDTH + 1;
`else
    localparam int c_FRAME_LEN = WIDTH;
`endif
    localparam int                 c_CNT_W    = $clog2(c_FRAME_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(c_FRAME_LEN - 1);

    localparam logic [0:0] c_ST_COLLECT = 1'b0;
    localparam logic [0:0] c_ST_READY   = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   r_data_out;
    logic [WIDTH-1:0]   w_word;
    logic               w_accept;
    logic               w_frame_done;
    logic               w_frame_ok;

    assign w_accept     = (r_state == c_ST_COLLECT) && bus.write_in;
    assign w_frame_done = w_accept && (r_count == c_LAST_CNT);

`ifdef DESER_PARITY_EN
    logic r_parity_err;

    // Last bit is the parity bit; the data word is already complete in r_shreg.
    assign w_word     = r_shreg;
    assign w_frame_ok = ~(^r_shreg ^ bus.data_in);
`else
    assign w_word     = {r_shreg[WIDTH-2:0], bus.data_in};
    assign w_frame_ok = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_COLLECT: if (w_frame_done && w_frame_ok) w_next_state = c_ST_READY;
            c_ST_READY:   if (bus.ack_in)                 w_next_state = c_ST_COLLECT;
            default:      w_next_state = c_ST_COLLECT;
        endcase
    end

    always_comb begin
        bus.data_ready = 1'b0;
        bus.status_out = 1'b0;
        if (r_state == c_ST_READY) begin
            bus.data_ready = 1'b1;
            bus.status_out = 1'b1;
        end
    end

    // Bits arriving in READY never reach w_accept, so they are simply lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count    <= '0;
            r_shreg    <= '0;
            r_data_out <= '0;
        end else if (w_accept) begin
            if (w_frame_done) begin
                r_count <= '0;
                if (w_frame_ok) begin
                    r_data_out <= w_word;
                end
            end else begin
                r_count <= r_count + c_CNT_W'(1);
                r_shreg <= {r_shreg[WIDTH-2:0], bus.data_in};
            end
        end
    end

`ifdef DESER_PARITY_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_frame_done && !w_frame_ok;
        end
    end

    assign bus.parity_err_out = r_parity_err;
`endif

    assign bus.data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_deserializer
// Description : Randomized and directed bench for deserializer, checked every
//               cycle against a bit-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deserializer;

    localparam int WIDTH = 8;
`ifdef DESER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    deserializer_if #(.WIDTH(WIDTH)) bus();

    deserializer #(.WIDTH(WIDTH)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total      = 0;
    int bad        = 0;
    int ready_seen = 0;

    // Reference state: bits of the frame in progress plus the held word
    bit               m_bits[$];
    bit               m_ready = 1'b0;
    logic [WIDTH-1:0] m_word  = '0;
    bit               m_perr  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit w, input bit d, input bit a, input bit r);
        int unsigned v;
        bit          p;
        if (r) begin
            m_bits.delete();
            m_ready = 1'b0;
            m_word  = '0;
            m_perr  = 1'b0;
        end else begin
            m_perr = 1'b0;
            if (m_ready) begin
                if (a) m_ready = 1'b0;
            end else if (w) begin
                m_bits.push_back(d);
                if (m_bits.size() == FRAME) begin
                    v = 0;
                    p = 1'b0;
                    for (int i = 0; i < WIDTH; i++) begin
                        v = v * 2 + int'(m_bits[i]);
                        p = p ^ m_bits[i];
                    end
`ifdef DESER_PARITY_EN
                    if (p == m_bits[WIDTH]) begin
                        m_word  = WIDTH'(v);
                        m_ready = 1'b1;
                    end else begin
                        m_perr = 1'b1;
                    end
`else
                    m_word  = WIDTH'(v);
                    m_ready = 1'b1;
`endif
                    m_bits.delete();
                end
            end
        end
    endtask

    task automatic cycle(input bit w, input bit d, input bit a, input bit r);
        bus.write_in = w;
        bus.data_in  = d;
        bus.ack_in   = a;
        rst          = r;
        @(posedge clk);
        model_edge(w, d, a, r);
        #1;
        if (bus.data_ready === 1'b1) ready_seen++;
        check_eq("data_out",   32'(bus.data_out), 32'(m_word));
        check_eq("data_ready", 32'(bus.data_ready), 32'(m_ready));
        check_eq("status_out", 32'(bus.status_out), 32'(m_ready));
`ifdef DESER_PARITY_EN
        check_eq("parity_err", 32'(bus.parity_err_out), 32'(m_perr));
`endif
    endtask

    task automatic idle(input int n, input bit a);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, a, 1'b0);
    endtask

    // Sends one frame MSB-first with up to maxgap idle cycles before each bit
    task automatic send_frame(input logic [WIDTH-1:0] word, input int maxgap,
                              input bit a, input bit badpar);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            idle(int'($urandom_range(0, maxgap)), a);
            cycle(1'b1, word[i], a, 1'b0);
        end
`ifdef DESER_PARITY_EN
        idle(int'($urandom_range(0, maxgap)), a);
        cycle(1'b1, (^word) ^ badpar, a, 1'b0);
`else
        if (badpar) idle(0, a);
`endif
    endtask

    initial begin
        logic [WIDTH-1:0] words[3];
        logic [WIDTH-1:0] w;
        int               rs0;
        bit               bp;

        bus.write_in = 1'b0;
        bus.data_in  = 1'b0;
        bus.ack_in   = 1'b0;

        // Reset state
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_data_out", 32'(bus.data_out), 32'h0);
        check_eq("rst_ready",    32'(bus.data_ready), 32'h0);
        check_eq("rst_status",   32'(bus.status_out), 32'h0);

        // First word 0xB2
        send_frame(8'hB2, 0, 1'b0, 1'b0);
        check_eq("b2_word",   32'(bus.data_out), 32'hB2);
        check_eq("b2_ready",  32'(bus.data_ready), 32'h1);
        check_eq("b2_status", 32'(bus.status_out), 32'h1);

        // Strobes while held are dropped
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        check_eq("held_word",  32'(bus.data_out), 32'hB2);
        check_eq("held_ready", 32'(bus.data_ready), 32'h1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("ack_ready", 32'(bus.data_ready), 32'h0);
        check_eq("ack_hold",  32'(bus.data_out), 32'hB2);
        send_frame(8'hFF, 0, 1'b0, 1'b0);
        check_eq("ff_word", 32'(bus.data_out), 32'hFF);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Ack tied high, a strobe every cycle
        words[0] = 8'h01;
        words[1] = 8'h80;
        words[2] = 8'h5A;
        rs0 = ready_seen;
        for (int k = 0; k < 3; k++) begin
            send_frame(words[k], 0, 1'b1, 1'b0);
            check_eq("stream_word",  32'(bus.data_out), 32'(words[k]));
            check_eq("stream_ready", 32'(bus.data_ready), 32'h1);
            cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
        check_eq("stream_ready_cnt", 32'(ready_seen - rs0), 32'd3);

        // Reset mid-word, then reset while a word is held
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h3C, 0, 1'b0, 1'b0);
        check_eq("3c_word",  32'(bus.data_out), 32'h3C);
        check_eq("3c_ready", 32'(bus.data_ready), 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rst2_data_out", 32'(bus.data_out), 32'h0);
        check_eq("rst2_ready",    32'(bus.data_ready), 32'h0);
        check_eq("rst2_status",   32'(bus.status_out), 32'h0);

        // Long strobe gaps and an ack/write collision
        send_frame(8'hC3, 20, 1'b0, 1'b0);
        check_eq("c3_word", 32'(bus.data_out), 32'hC3);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("collide_ready", 32'(bus.data_ready), 32'h0);
        send_frame(8'h0F, 20, 1'b0, 1'b0);
        check_eq("0f_word",  32'(bus.data_out), 32'h0F);
        check_eq("0f_ready", 32'(bus.data_ready), 32'h1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef DESER_PARITY_EN
        send_frame(8'hB2, 0, 1'b0, 1'b0);
        check_eq("par_ok_ready", 32'(bus.data_ready), 32'h1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hB2 ^ 8'h01, 0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hB2, 0, 1'b0, 1'b1);
        check_eq("par_bad_pulse", 32'(bus.parity_err_out), 32'h1);
        check_eq("par_bad_ready", 32'(bus.data_ready), 32'h0);
        check_eq("par_bad_word",  32'(bus.data_out), 32'hB3);
        idle(1, 1'b0);
        check_eq("par_bad_end", 32'(bus.parity_err_out), 32'h0);
`endif

        // Random traffic: gaps, dropped strobes while held, random acks
        for (int n = 0; n < 30; n++) begin
            w  = WIDTH'($urandom);
`ifdef DESER_PARITY_EN
            bp = ($urandom_range(0, 7) == 0);
`else
            bp = 1'b0;
`endif
            send_frame(w, int'($urandom_range(0, 3)), 1'b0, bp);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++)
                cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
